// File: rtl/ifu_fetch_pkg.sv
// rtl/ifu_fetch_pkg.sv - shared encodings and reset PC for the instruction fetch unit
package ifu_fetch_pkg;

  typedef enum logic [1:0] {
    N_NPC   = 2'd0,
    J_NPC   = 2'd1,
    JR_NPC  = 2'd2,
    BEQ_NPC = 2'd3
  } npc_sel_e;

  typedef enum logic [1:0] {
    IFU_FETCH = 2'd0,
    IFU_EXEC  = 2'd1,
    IFU_HALT  = 2'd2
  } ifu_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

endpackage

// File: rtl/npc_calc.sv
// rtl/npc_calc.sv - combinational next-PC select and target alignment check
module npc_calc
  import ifu_fetch_pkg::*;
(
  input  logic [31:0] pc,
  // only the jump index / branch immediate field of the instruction is needed
  input  logic [25:0] instr,
  input  logic [1:0]  s_npc,
  input  logic [31:0] rs_data,
  output logic [31:0] npc,
  output logic        misaligned
);

  logic [31:0] seq_pc;
  logic [31:0] br_off;

  always_comb begin
    seq_pc = pc + 32'd4;
    br_off = {{14{instr[15]}}, instr[15:0], 2'b00};
    case (npc_sel_e'(s_npc))
      N_NPC:   npc = seq_pc;
      J_NPC:   npc = {seq_pc[31:28], instr[25:0], 2'b00};
      JR_NPC:  npc = rs_data;
      BEQ_NPC: npc = seq_pc + br_off;
      default: npc = seq_pc;
    endcase
  end

  assign misaligned = |npc[1:0];

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - multi-cycle instruction fetch FSM with execute stall and alignment-fault halt
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  input  logic [1:0]       s_npc,
  input  logic [31:0]      rs_data,
  input  logic             stall,
  output logic [CNT_W-1:0] icount,
  output logic             fault
);

  ifu_state_e       state, state_n;
  logic [31:0]      pc_n, instr_n, npc;
  logic             valid_n, fault_n, misaligned;
  logic [CNT_W-1:0] icount_n;

  npc_calc u_npc_calc (
    .pc         (pc),
    .instr      (instr[25:0]),
    .s_npc      (s_npc),
    .rs_data    (rs_data),
    .npc        (npc),
    .misaligned (misaligned)
  );

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    instr_n  = instr;
    valid_n  = instr_valid;
    icount_n = icount;
    fault_n  = fault;
    case (state)
      IFU_FETCH: begin
        // an ack only counts once our request is actually on the bus
        if (imem_req && imem_ack) begin
          instr_n = imem_rdata;
          valid_n = 1'b1;
          state_n = IFU_EXEC;
        end
      end
      IFU_EXEC: begin
        if (!stall) begin
          valid_n = 1'b0;
          if (misaligned) begin
            fault_n = 1'b1;
            state_n = IFU_HALT;
          end else begin
            pc_n     = npc;
            icount_n = icount + CNT_W'(1);
            state_n  = IFU_FETCH;
          end
        end
      end
      default: begin
        valid_n = 1'b0;
        state_n = IFU_HALT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IFU_FETCH;
      pc          <= RESET_PC;
      instr       <= 32'd0;
      instr_valid <= 1'b0;
      icount      <= '0;
      fault       <= 1'b0;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instr       <= instr_n;
      instr_valid <= valid_n;
      icount      <= icount_n;
      fault       <= fault_n;
      imem_req    <= (state_n == IFU_FETCH);
      imem_addr   <= pc_n;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - scoreboard bench for ifu_fetch with directed and randomized fetch/exec traffic
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = 32'd0;
  logic [31:0] instr, pc, pc_plus4, rs_data = 32'd0;
  logic        instr_valid, fault, stall = 1'b0;
  logic [1:0]  s_npc = 2'd0;
  logic [31:0] icount;

  ifu_fetch dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4), .s_npc(s_npc),
    .rs_data(rs_data), .stall(stall), .icount(icount), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] cnt; } fetch_t;
  typedef struct { logic [31:0] ins;  logic [31:0] pc;  } exec_t;
  fetch_t fetch_q[$];
  exec_t  exec_q[$];

  int total = 0;
  int bad = 0;
  logic [31:0] m_pc;
  logic [31:0] m_count;
  logic        m_fault;
  logic        req_prev = 1'b0;
  logic        valid_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_npc(input logic [31:0] cur, input logic [31:0] w,
                                            input logic [1:0] sel, input logic [31:0] rs);
    logic [31:0] seq;
    seq = cur + 32'd4;
    case (sel)
      2'd0:    return seq;
      2'd1:    return {seq[31:28], w[25:0], 2'b00};
      2'd2:    return rs;
      default: return seq + 32'($signed(w[15:0])) * 4;
    endcase
  endfunction

  always @(negedge clk) begin
    fetch_t f;
    exec_t  e;
    if (rst_n) begin
      if (imem_req && !req_prev) begin
        if (fetch_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_fetch act_addr=%h exp=none", imem_addr);
        end else begin
          f = fetch_q.pop_front();
          chk("fetch_addr", imem_addr, f.addr);
          chk("fetch_pc", pc, f.addr);
          chk("fetch_icount", icount, f.cnt);
        end
      end
      if (instr_valid && !valid_prev) begin
        if (exec_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_exec act_instr=%h exp=none", instr);
        end else begin
          e = exec_q.pop_front();
          chk("exec_instr", instr, e.ins);
          chk("exec_pc", pc, e.pc);
          chk("exec_pc_plus4", pc_plus4, e.pc + 32'd4);
        end
      end
    end
    req_prev   = imem_req;
    valid_prev = instr_valid;
  end

  task automatic wait_req();
    for (int i = 0; i < 20 && !imem_req; i++) @(negedge clk);
    chk("req_wait", {31'd0, imem_req}, 32'd1);
  endtask

  task automatic run_instr(input logic [31:0] w, input logic [1:0] sel,
                           input logic [31:0] rs, input int lat, input int nstall);
    logic [31:0] npc;
    wait_req();
    repeat (lat) @(negedge clk);
    imem_ack = 1'b1;
    imem_rdata = w;
    exec_q.push_back('{ins: w, pc: m_pc});
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    chk("exec_entry", {31'd0, instr_valid}, 32'd1);
    s_npc = sel;
    rs_data = rs;
    npc = model_npc(m_pc, w, sel, rs);
    stall = 1'b1;
    for (int i = 0; i < nstall; i++) begin
      imem_ack = 1'($urandom);
      imem_rdata = $urandom;
      @(negedge clk);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
      chk("stall_instr", instr, w);
      chk("stall_icount", icount, m_count);
      chk("stall_pc", pc, m_pc);
      chk("stall_fault", {31'd0, fault}, 32'd0);
    end
    imem_ack = 1'b0;
    stall = 1'b0;
    if (npc[1:0] == 2'b00) begin
      fetch_q.push_back('{addr: npc, cnt: m_count + 32'd1});
      m_pc = npc;
      m_count = m_count + 32'd1;
    end else begin
      m_fault = 1'b1;
    end
    @(negedge clk);
    chk("commit_valid", {31'd0, instr_valid}, 32'd0);
    chk("commit_fault", {31'd0, fault}, {31'd0, m_fault});
    chk("commit_icount", icount, m_count);
    chk("commit_pc", pc, m_pc);
    s_npc = 2'($urandom);
    stall = 1'($urandom);
  endtask

  task automatic check_halt();
    for (int i = 0; i < 10; i++) begin
      imem_ack = 1'($urandom);
      @(negedge clk);
      chk("halt_req", {31'd0, imem_req}, 32'd0);
      chk("halt_valid", {31'd0, instr_valid}, 32'd0);
      chk("halt_pc", pc, m_pc);
      chk("halt_icount", icount, m_count);
      chk("halt_fault", {31'd0, fault}, 32'd1);
    end
    imem_ack = 1'b0;
  endtask

  task automatic start_reset();
    rst_n = 1'b0;
    fetch_q.delete();
    exec_q.delete();
    m_pc = 32'h0000_3000;
    m_count = 32'd0;
    m_fault = 1'b0;
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0000_3000);
    chk("rst_pc", pc, 32'h0000_3000);
    chk("rst_instr", instr, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_icount", icount, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
  endtask

  // release with a stale ack still high: it must not be latched
  task automatic release_reset();
    repeat (2) @(negedge clk);
    fetch_q.push_back('{addr: 32'h0000_3000, cnt: 32'd0});
    rst_n = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("post_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("post_rst_instr", instr, 32'd0);
  endtask

  initial begin
    logic [31:0] w, rs;
    logic [1:0]  sel;
    @(negedge clk);
    start_reset();
    release_reset();

    run_instr(32'h2008_0005, 2'd0, 32'd0, 3, 0);
    run_instr(32'h2008_0001, 2'd0, 32'd0, 1, 0);
    run_instr(32'h0800_0C10, 2'd1, 32'd0, 0, 0);
    run_instr(32'h0000_0008, 2'd2, 32'h0000_3010, 2, 0);
    run_instr(32'h1000_FFFC, 2'd3, 32'd0, 0, 0);
    run_instr(32'h0000_0008, 2'd2, 32'h0000_3010, 1, 0);
    run_instr(32'h1000_FFFC, 2'd0, 32'd0, 0, 0);
    run_instr(32'h2008_0002, 2'd0, 32'd0, 2, 4);
    run_instr(32'h0000_0008, 2'd2, 32'h0000_3022, 1, 0);
    check_halt();

    @(negedge clk);
    start_reset();
    release_reset();
    run_instr(32'h2008_0003, 2'd0, 32'd0, 0, 0);
    wait_req();
    @(negedge clk);
    start_reset();
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    release_reset();

    run_instr(32'h0000_0008, 2'd2, 32'hFFFF_FFFC, 1, 0);
    run_instr(32'h2008_0004, 2'd0, 32'd0, 0, 1);
    chk("wrap_pc", pc, 32'd0);

    for (int n = 0; n < 30; n++) begin
      w = $urandom;
      rs = $urandom;
      rs[1:0] = 2'b00;
      sel = 2'($urandom_range(0, 3));
      run_instr(w, sel, rs, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    rs = $urandom;
    rs[0] = 1'b1;
    run_instr($urandom, 2'd2, rs, 1, 2);
    check_halt();
    chk("fetch_q_drained", fetch_q.size(), 32'd0);
    chk("exec_q_drained", exec_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit; the producing end of the controller interface. Fetches each instruction word over a variable-latency instruction-memory handshake and presents it (op/funct/rs/rt/imm fields) to the controller.
- Consumes the controller's s_npc selection, the zero-qualified branch decision and the rs operand to form the next PC.
- Sits between instruction memory and ctrl/datapath.
- Adds multi-cycle fetch, execute-stall and an alignment-fault halt.

Parameters:
RESET_PC, 32'h0000_3000, PC loaded on reset; must be word-aligned.
CNT_W, 32, width of retired-instruction counter.

Ports:
clk  in  1  system clock
rst_n  in  1  reset
imem_req  out  1  fetch request, registered
imem_addr  out  32  fetch address (= pc), registered
imem_ack  in  1  read data valid this cycle
imem_rdata  in  32  instruction word
instr  out  32  current instruction to controller/datapath
instr_valid  out  1  instr is executing this cycle
pc  out  32  address of current instruction
pc_plus4  out  32  pc+4, for JAL link value
s_npc  in  2  next-PC select from controller
rs_data  in  32  register rs value, JR target
stall  in  1  datapath hold; freezes EXEC
icount  out  CNT_W  retired instructions
fault  out  1  sticky misaligned-target fault

Interface decision: one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH, pc=RESET_PC, instr=0, instr_valid=0, icount=0, fault=0.
  - imem_req=0 while in reset; imem_addr=RESET_PC.
  - Reset mid-fetch drops imem_req immediately; the pending ack is not waited on.
- States FETCH, EXEC, HALT. All outputs come from registers; pc_plus4 = pc+4 combinationally.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack: instr<=imem_rdata, instr_valid<=1, imem_req<=0, go EXEC.
  - Minimum fetch latency: ack in the first FETCH cycle → EXEC next cycle.
- EXEC:
  - instr_valid=1; ctrl decodes instr combinationally and drives s_npc in the same cycle.
  - stall=1: hold all state.
  - stall=0: pc<=npc, icount<=icount+1 (wraps at 2^CNT_W), instr_valid<=0, go FETCH.
  - Back-to-back instructions take ≥2 cycles each.
- npc by s_npc:
  - 2'b00 N: pc+4
  - 2'b01 J: {pc_plus4[31:28], instr[25:0], 2'b00}
  - 2'b10 JR: rs_data
  - 2'b11 BEQ: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00})
  - All 32-bit modulo arithmetic; pc 32'hFFFF_FFFC + 4 wraps to 0.
- Fault:
  - If the EXEC commit would load npc[1:0]≠0 (only reachable via JR), do not update pc.
  - Set fault=1, leave icount unchanged, go HALT.
- HALT: imem_req=0, instr_valid=0, pc frozen; exit only via reset.
- imem_ack outside FETCH: ignored; instr unchanged.
- stall in FETCH/HALT: ignored.
- Simultaneous stall=1 and misaligned JR: stall wins; the fault is evaluated at the commit cycle.

Decomposition:
- Shared def.v:
  - s_npc encodings N_nPC=0, J_nPC=1, JR_nPC=2, BEQ_nPC=3.
  - State encodings IFU_FETCH, IFU_EXEC, IFU_HALT.
  - RESET_PC default.
- One sub-module, npc_calc: combinational next-PC mux/adders.
  - Inputs: pc, instr, s_npc, rs_data.
  - Outputs: npc, misaligned.
- The FSM, counters and registers stay in ifu_fetch.

Test Plan:
1. Reset release, ack after 3 cycles with rdata=32'h2008_0005 (addi), s_npc=0 → imem_addr=32'h3000 during fetch; instr_valid for one cycle; next imem_addr=32'h3004; icount=1.
2. J: pc=32'h3008, instr=32'h0800_0C10, s_npc=1 → next imem_addr=32'h0000_3040.
3. BEQ taken: pc=32'h3010, imm=16'hFFFC, s_npc=3 → next addr 32'h3004. BEQ not taken (s_npc=0) → 32'h3014.
4. JR rs_data=32'h3022 → fault=1, HALT; imem_req stays 0 for 10 cycles; icount unchanged; pc=32'h3010-equivalent current pc held.
5. stall=1 for 4 EXEC cycles → instr_valid stays 1, no fetch, icount unchanged; on release, single commit.
6. Assert rst_n=0 while imem_req=1 awaiting ack, late ack arrives during reset → imem_req drops immediately; after release, fetch restarts at 32'h3000 and the stale ack is not latched.
